input_event_arbiter: RTL and testbench
======================================

// Module: input_event_arbiter
// PURPOSE
//  Front-end controller for the vending machine's coin/button inputs.
//  - Synchronises N asynchronous level inputs and detects their rising edges.
//  - Latches each edge as a pending event.
//  - Round-robin arbitrates pending events into one valid/ready event stream for the main vending FSM.
//  - Guarantees no simultaneous press is lost, and flags true overruns.
// PARAMETERS
//  N_INPUTS     4  number of independent level inputs (coins + buttons), 2..16
//  SYNC_STAGES  2  synchroniser flops per input before edge detection, >=2
//  IDX_W        $clog2(N_INPUTS)  derived width of the event index (localparam)
// PORTS
//  clk_i          in   1         system clock
//  rst_i          in   1         reset, asynchronous, active-high
//  sig_i          in   N_INPUTS  raw asynchronous level inputs
//  evt_valid_o    out  1         event offered to consumer
//  evt_ready_i    in   1         consumer accepts event this cycle
//  evt_idx_o      out  IDX_W     index of offered input; stable while valid & !ready
//  pending_o      out  N_INPUTS  edges latched, not yet loaded to the output
//  overflow_o     out  N_INPUTS  sticky per-input overrun flag
//  ovf_clr_i      in   1         clears all overflow_o bits (1-cycle pulse)
// BEHAVIOUR
//  Reset
//  - All flops clear: sync chains, edge history, pending, overflow, evt_valid_o, evt_idx_o.
//  - RR pointer resets to N_INPUTS-1, so input 0 wins first.
//  Arming
//  - Arm counter masks edge detection for SYNC_STAGES+1 cycles after rst_i deasserts.
//  - Edge history tracks the sync output during that window.
//  - An input held high through reset produces NO event.
//  Edge detection
//  - edge[i] = sync_out[i] & ~prev[i].
//  - Latency (SYNC_STAGES=2), counting clock edges from the first edge sampling sig_i[i]=1:
//    - internal edge pulse after edge 2 (combinational);
//    - pending_o[i] high after edge 3.
//  - Levels shorter than one clock are not guaranteed to be seen.
//  Pending / overflow
//  - pending[i] sets on edge[i] and clears when i is loaded into the output register.
//  - Set and clear in the same cycle: pending stays 1 (the new edge is a new event).
//  - edge[i] while pending[i]=1 and not being cleared: pending unchanged, overflow[i] sets.
//  - ovf_clr_i together with a new overrun: overrun wins (bit stays 1).
//  FSM states
//  - IDLE (valid=0): when any pending bit is 1, load the RR winner, clear its pending bit, assert valid, go to OFFER.
//    - Latency from pending to valid: 1 cycle.
//  - OFFER (valid=1): hold evt_idx_o while !evt_ready_i.
//    - On valid&ready with another bit pending: load the next winner in the same cycle (back-to-back, 1 event/clk).
//    - On valid&ready with nothing pending: go to IDLE.
//  Round-robin
//  - Search order: ptr+1 .. ptr (wrapping modulo N_INPUTS).
//  - ptr is updated to the granted index on every load.
//  - Simultaneous edges are served in RR order with none lost.
//  Reset mid-operation
//  - Asynchronous clear of all state.
//  - Pending and offered events are discarded; the arm window restarts.
// STRUCTURE
//  - vending_pkg: typedef enum logic {ST_IDLE, ST_OFFER} arb_state_t; function rr_pick(req, ptr) returning winner index.
//  - Sub-module input_sync_edge (one per input via generate):
//    - async-reset SYNC_STAGES synchroniser + prev flop + arm-masked rising-edge output;
//    - ports clk_i, rst_i, arm_i, sig_i, edge_o.
//  - Top level holds the arm counter, pending/overflow registers, RR pointer, FSM and output register.
// TESTING
//  1. Reset with sig_i=4'b0010 held high -> after release no evt_valid_o and pending_o=0 for 20 clk.
//  2. Single press: sig_i[2] 0->1 for 5 clk -> pending_o[2] 3 clk later; valid with idx=2 next clk;
//     ready=1 -> valid drops next clk.
//  3. Simultaneous: sig_i 0->4'b1011, ready=1 -> idx sequence 0,1,3 on consecutive clks, no gaps.
//  4. Back-pressure: ready=0, press input 1 -> idx=1 held stable 10 clk; press input 3 meanwhile
//     -> pending_o[3]=1, served right after ready=1.
//  5. Overrun: ready=0, input 0 offered; two more presses on input 0 -> first sets pending_o[0],
//     second sets overflow_o[0]; ovf_clr_i clears it.
//  6. rst_i asserted mid-OFFER with pending=4'b0110 -> all outputs 0 immediately; no events after release.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and the round-robin winner search for the vending input arbiter.
package vending_pkg;

   typedef enum logic {ST_IDLE, ST_OFFER} arb_state_t;

   localparam int MAX_INPUTS = 16;
   localparam int MAX_IDX_W  = 4;

   // Scans ptr+1 .. ptr modulo n; returns ptr unchanged when req is empty.
   function automatic logic [MAX_IDX_W-1:0] rr_pick(input logic [MAX_INPUTS-1:0] req,
                                                    input logic [MAX_IDX_W-1:0]  ptr,
                                                    input int                    n);
      logic [MAX_IDX_W-1:0] win;
      logic [MAX_IDX_W:0]   idx;
      logic                 found;
      win   = ptr;
      found = 1'b0;
      for (int k = 1; k <= MAX_INPUTS; k++) begin
         idx = 5'(int'(ptr) + k);
         if (idx >= 5'(n)) begin
            idx = idx - 5'(n);
         end
         if (!found && (k <= n) && req[idx[MAX_IDX_W-1:0]]) begin
            win   = idx[MAX_IDX_W-1:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/input_sync_edge.sv
// Multi-flop synchroniser for one raw level input with an arm-gated rising-edge pulse.
module input_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic arm_i,
   input  logic sig_i,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};

   // prev keeps following the synchronised level while disarmed, so a level
   // already high at arm time never looks like a fresh edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_o = arm_i & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/input_event_arbiter.sv
// Coin/button front end: synchronise, detect edges, latch pending events and
// round-robin them onto a single valid/ready stream with per-input overrun flags.
module input_event_arbiter
   import vending_pkg::*;
#(
   parameter  int N_INPUTS    = 4,
   parameter  int SYNC_STAGES = 2,
   localparam int IDX_W       = $clog2(N_INPUTS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_INPUTS-1:0] sig_i,
   output logic                evt_valid_o,
   input  logic                evt_ready_i,
   output logic [IDX_W-1:0]    evt_idx_o,
   output logic [N_INPUTS-1:0] pending_o,
   output logic [N_INPUTS-1:0] overflow_o,
   input  logic                ovf_clr_i
);

   localparam int ARM_CYCLES = SYNC_STAGES + 1;
   localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

   logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
   logic                arm;
   logic [N_INPUTS-1:0] edge_vec;
   logic [N_INPUTS-1:0] clr_vec;
   logic [N_INPUTS-1:0] pending_q, pending_d;
   logic [N_INPUTS-1:0] overflow_q, overflow_d;
   logic [IDX_W-1:0]    ptr_q, idx_q, grant_idx;
   arb_state_t          state_q, state_d;
   logic                any_pending;
   logic                load_en;

   assign arm       = (arm_cnt_q == ARM_W'(ARM_CYCLES));
   assign arm_cnt_d = arm ? arm_cnt_q : arm_cnt_q + ARM_W'(1);

   assign any_pending = |pending_q;
   assign grant_idx   = IDX_W'(rr_pick(MAX_INPUTS'(pending_q), MAX_IDX_W'(ptr_q), N_INPUTS));

   // A new edge on the input being granted is a fresh event, so set beats clear.
   for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_in
      input_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .arm_i  (arm),
         .sig_i  (sig_i[gi]),
         .edge_o (edge_vec[gi])
      );

      assign clr_vec[gi]    = load_en && (grant_idx == IDX_W'(gi));
      assign pending_d[gi]  = edge_vec[gi] | (pending_q[gi] & ~clr_vec[gi]);
      assign overflow_d[gi] = (edge_vec[gi] & pending_q[gi] & ~clr_vec[gi])
                            | (overflow_q[gi] & ~ovf_clr_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (any_pending) state_d = ST_OFFER;
         ST_OFFER: if (evt_ready_i && !any_pending) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      load_en = 1'b0;
      case (state_q)
         ST_IDLE:  load_en = any_pending;
         ST_OFFER: load_en = evt_ready_i && any_pending;
         default:  load_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         arm_cnt_q  <= '0;
         pending_q  <= '0;
         overflow_q <= '0;
         ptr_q      <= IDX_W'(N_INPUTS - 1);
         idx_q      <= '0;
      end else begin
         arm_cnt_q  <= arm_cnt_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         if (load_en) begin
            ptr_q <= grant_idx;
            idx_q <= grant_idx;
         end
      end
   end

   assign evt_valid_o = (state_q == ST_OFFER);
   assign evt_idx_o   = idx_q;
   assign pending_o   = pending_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_input_event_arbiter.sv
// Self-checking bench: directed tables, hand sequences and random traffic against an event-level model.
module tb_input_event_arbiter;

   localparam int N = 4;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] sig = 4'b0;
   logic       ready = 1'b0;
   logic       clr = 1'b0;
   logic       valid;
   logic [1:0] idx;
   logic [3:0] pend;
   logic [3:0] ovf;

   int errors = 0;
   int checks = 0;

   input_event_arbiter #(
      .N_INPUTS    (N),
      .SYNC_STAGES (S)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .sig_i       (sig),
      .evt_valid_o (valid),
      .evt_ready_i (ready),
      .evt_idx_o   (idx),
      .pending_o   (pend),
      .overflow_o  (ovf),
      .ovf_clr_i   (clr)
   );

   always #5 clk = ~clk;

   // Reference model: sampled input history plus a set of pending events and one offered event.
   logic [3:0] hist[$];
   int         m_k;
   logic       m_valid;
   int         m_idx;
   int         m_ptr;
   logic [3:0] m_pend;
   logic [3:0] m_ovf;

   function automatic logic [3:0] samp(int back);
      if (m_k - back < 1 || back >= hist.size()) return 4'b0;
      return hist[back];
   endfunction

   task automatic model_reset();
      hist.delete();
      m_k     = 0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = N - 1;
      m_pend  = 4'b0;
      m_ovf   = 4'b0;
   endtask

   task automatic model_step(input logic [3:0] s, input logic r, input logic c);
      logic [3:0] e;
      logic [3:0] take;
      int         w;
      // A press is seen once its first high sample has crossed S-1 further clocks, and only when armed.
      e    = (m_k >= S + 1) ? (samp(S - 1) & ~samp(S)) : 4'b0;
      take = 4'b0;
      if (!m_valid || r) begin
         m_valid = 1'b0;
         for (int j = 1; j <= N; j++) begin
            w = (m_ptr + j) % N;
            if (!m_valid && m_pend[w]) begin
               m_valid = 1'b1;
               m_idx   = w;
               take[w] = 1'b1;
            end
         end
         if (m_valid) m_ptr = m_idx;
      end
      m_ovf  = (c ? 4'b0 : m_ovf) | (e & m_pend & ~take);
      m_pend = e | (m_pend & ~take);
      hist.push_front(s);
      if (hist.size() > 8) void'(hist.pop_back());
      m_k++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Entered at a falling edge; drives inputs, advances the model, checks at the next falling edge.
   task automatic tick(input logic [3:0] s, input logic r, input logic c, input logic rs);
      sig   = s;
      ready = r;
      clr   = c;
      rst   = rs;
      if (rs) model_reset();
      else    model_step(s, r, c);
      @(negedge clk);
      check("model", {21'b0, valid, idx, pend, ovf}, {21'b0, m_valid, 2'(m_idx), m_pend, m_ovf});
   endtask

   typedef struct {
      logic       rs;
      logic [3:0] s;
      logic       r;
      logic       ev;
      logic [1:0] ei;
      logic [3:0] ep;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rs, input logic [3:0] s, input logic r,
                      input logic ev, input logic [1:0] ei, input logic [3:0] ep);
      vec_t v;
      v.rs = rs; v.s = s; v.r = r; v.ev = ev; v.ei = ei; v.ep = ep;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] rs_sig;
      model_reset();

      // Single press on input 2, then simultaneous 1011 after a fresh reset.
      add(0, 4'b0100, 0, 0, 2'd0, 4'b0000);
      add(0, 4'b0100, 0, 0, 2'd0, 4'b0000);
      add(0, 4'b0100, 0, 0, 2'd0, 4'b0100);
      add(0, 4'b0100, 0, 1, 2'd2, 4'b0000);
      add(0, 4'b0100, 1, 0, 2'd2, 4'b0000);
      add(0, 4'b0000, 0, 0, 2'd2, 4'b0000);
      add(0, 4'b0000, 0, 0, 2'd2, 4'b0000);
      add(1, 4'b0000, 0, 0, 2'd0, 4'b0000);
      for (int i = 0; i < 4; i++) add(0, 4'b0000, 1, 0, 2'd0, 4'b0000);
      add(0, 4'b1011, 1, 0, 2'd0, 4'b0000);
      add(0, 4'b1011, 1, 0, 2'd0, 4'b0000);
      add(0, 4'b1011, 1, 0, 2'd0, 4'b1011);
      add(0, 4'b1011, 1, 1, 2'd0, 4'b1010);
      add(0, 4'b1011, 1, 1, 2'd1, 4'b1000);
      add(0, 4'b1011, 1, 1, 2'd3, 4'b0000);
      add(0, 4'b1011, 1, 0, 2'd3, 4'b0000);
      add(0, 4'b0000, 0, 0, 2'd3, 4'b0000);
      add(0, 4'b0000, 0, 0, 2'd3, 4'b0000);

      @(negedge clk);
      // Input 1 held high through reset must never produce an event.
      tick(4'b0010, 0, 0, 1);
      tick(4'b0010, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         tick(4'b0010, 0, 0, 0);
         check("held_rst", {30'b0, valid, |pend}, 32'd0);
      end
      for (int i = 0; i < 3; i++) tick(4'b0000, 0, 0, 0);
      $display("held-through-reset: 20 idle cycles checked");

      foreach (tbl[i]) begin
         tick(tbl[i].s, tbl[i].r, 1'b0, tbl[i].rs);
         check("table", {21'b0, valid, idx, pend, ovf},
               {21'b0, tbl[i].ev, tbl[i].ei, tbl[i].ep, 4'b0000});
         $display("vec %0d: sig=%b rdy=%b -> valid=%b idx=%0d pend=%b", i, tbl[i].s, tbl[i].r, valid, idx, pend);
      end

      // Back-pressure: idx 1 held while input 3 queues behind it.
      for (int i = 1; i <= 4; i++) tick(4'b0010, 0, 0, 0);
      check("bp_offer", {29'b0, valid, idx}, {29'b0, 1'b1, 2'd1});
      for (int i = 5; i <= 14; i++) begin
         tick(4'b1010, 0, 0, 0);
         check("bp_hold", {29'b0, valid, idx}, {29'b0, 1'b1, 2'd1});
      end
      check("bp_pend", {28'b0, pend}, 32'b1000);
      tick(4'b1010, 1, 0, 0);
      check("bp_next", {25'b0, valid, idx, pend}, {25'b0, 1'b1, 2'd3, 4'b0000});
      tick(4'b1010, 1, 0, 0);
      check("bp_drain", {31'b0, valid}, 32'd0);
      for (int i = 0; i < 3; i++) tick(4'b0000, 0, 0, 0);
      $display("back-pressure sequence done");

      // Overrun on input 0 while its first event is still being offered.
      for (int i = 0; i < 4; i++) tick(4'b0001, 0, 0, 0);
      check("ovr_offer", {29'b0, valid, idx}, {29'b0, 1'b1, 2'd0});
      for (int i = 0; i < 2; i++) tick(4'b0000, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(4'b0001, 0, 0, 0);
      check("ovr_first", {24'b0, pend, ovf}, {24'b0, 4'b0001, 4'b0000});
      for (int i = 0; i < 2; i++) tick(4'b0000, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(4'b0001, 0, 0, 0);
      check("ovr_second", {24'b0, pend, ovf}, {24'b0, 4'b0001, 4'b0001});
      tick(4'b0001, 0, 1, 0);
      check("ovr_clr", {28'b0, ovf}, 32'd0);
      tick(4'b0000, 1, 0, 0);
      check("ovr_reload", {25'b0, valid, idx, pend}, {25'b0, 1'b1, 2'd0, 4'b0000});
      tick(4'b0000, 1, 0, 0);
      check("ovr_idle", {31'b0, valid}, 32'd0);
      $display("overrun sequence done");

      // Asynchronous reset in the middle of an offer with 0110 pending.
      for (int i = 0; i < 4; i++) tick(4'b1000, 0, 0, 0);
      check("mid_offer", {29'b0, valid, idx}, {29'b0, 1'b1, 2'd3});
      for (int i = 0; i < 3; i++) tick(4'b1110, 0, 0, 0);
      check("mid_pend", {28'b0, pend}, 32'b0110);
      #2 rst = 1'b1;
      model_reset();
      #1 check("async_rst", {21'b0, valid, idx, pend, ovf}, 32'd0);
      @(negedge clk);
      check("model", {21'b0, valid, idx, pend, ovf}, {21'b0, m_valid, 2'(m_idx), m_pend, m_ovf});
      for (int i = 0; i < 20; i++) begin
         tick(4'b1110, 1, 0, 0);
         check("post_rst", {30'b0, valid, |pend}, 32'd0);
      end
      for (int i = 0; i < 3; i++) tick(4'b0000, 0, 0, 0);
      $display("mid-offer reset sequence done");

      // Random traffic against the model, including overruns, clears and resets.
      for (int i = 0; i < 500; i++) begin
         rs_sig = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
         tick(sig ^ rs_sig, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 149) == 0));
      end
      $display("random phase: 500 cycles compared with model");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
